osc_sequencer: RTL and testbench

Control sequencer for the DDS oscillator datapath. It fetches per-frequency coefficient pairs (init1 amplitude seed, init2 recurrence coefficient) from a synchronous coefficient table. It then starts the oscillator with a one-cycle Ready pulse, generates the sample-rate Enable strobe, and issues atomic frequency-change updates (new init1/init2 together with a FreqChng pulse) while the oscillator keeps running. It sits between the host/register front end and the oscillator core in the function-generator clock domain.

---
 rtl/osc_sequencer.sv | 116 +++++++++++
 tb/tb_osc_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_sequencer.sv
// DDS oscillator sequencer: fetches init1/init2 pairs, issues Ready/FreqChng, and divides Enable.
// Start->Ready 3 cycles and FreqReq->FreqChng 3 cycles with a zero-wait table; table stalls hold the FSM until Stop.
module osc_sequencer #(
  parameter int IDX_W = 6,
  parameter int DIV_W = 16
) (
  input  logic             Fg_clk,
  input  logic             Resetn,
  input  logic             Start,
  input  logic             Stop,
  input  logic             FreqReq,
  input  logic [IDX_W-1:0] FreqSel,
  input  logic [2:0]       ModeSel,
  input  logic [DIV_W-1:0] RateDiv,
  output logic             rom_req,
  output logic [IDX_W:0]   rom_addr,
  input  logic             rom_valid,
  input  logic [31:0]      rom_data,
  output logic             Enable,
  output logic             Ready,
  output logic             FreqChng,
  output logic [2:0]       Mode,
  output logic [31:0]      init1,
  output logic [31:0]      init2,
  output logic             Busy,
  output logic             Running
);

  typedef enum logic [2:0] {IDLE, LD_A, LD_B, ARM, RUN, UP_A, UP_B, COMMIT} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, pend_idx;
  logic             pend;
  logic [31:0]      shadow1;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic             en_nxt;
  logic             fetch_a, fetch_b;

  function automatic logic is_active(state_t s);
    return (s == RUN) || (s == UP_A) || (s == UP_B) || (s == COMMIT);
  endfunction

  assign fetch_a = (state == LD_A) || (state == UP_A);
  assign fetch_b = (state == LD_B) || (state == UP_B);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = LD_A;
      LD_A:    if (rom_valid) state_nxt = LD_B;
      LD_B:    if (rom_valid) state_nxt = ARM;
      ARM:     state_nxt = RUN;
      RUN:     if (FreqReq || pend) state_nxt = UP_A;
      UP_A:    if (rom_valid) state_nxt = UP_B;
      UP_B:    if (rom_valid) state_nxt = COMMIT;
      COMMIT:  state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    // Stop wins over everything, including a same-cycle Start in IDLE.
    if (Stop) state_nxt = IDLE;
  end

  // Enable is registered: compute the count and strobe for the cycle being entered.
  always_comb begin
    cnt_nxt = '0;
    if (is_active(state) && !Enable) cnt_nxt = cnt + DIV_W'(1);
    en_nxt = is_active(state_nxt) && (cnt_nxt == RateDiv);
  end

  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      state    <= IDLE;
      idx      <= '0;
      pend     <= 1'b0;
      pend_idx <= '0;
      shadow1  <= '0;
      init1    <= '0;
      init2    <= '0;
      Mode     <= '0;
      cnt      <= '0;
      Enable   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      Enable <= en_nxt;
      if (state == IDLE && state_nxt == LD_A) begin
        idx  <= FreqSel;
        Mode <= ModeSel;
      end
      if (state == RUN) begin
        if (FreqReq) idx <= FreqSel;
        else if (pend) idx <= pend_idx;
      end
      // Retunes arriving mid-fetch coalesce into one pending index; the latest wins.
      if (Stop || state == RUN) begin
        pend <= 1'b0;
      end else if (FreqReq && state != IDLE) begin
        pend     <= 1'b1;
        pend_idx <= FreqSel;
      end
      if (fetch_a && rom_valid) shadow1 <= rom_data;
      if (fetch_b && rom_valid && !Stop) begin
        init1 <= shadow1;
        init2 <= rom_data;
      end
    end
  end

  assign rom_req  = fetch_a || fetch_b;
  assign rom_addr = {idx, fetch_b};
  assign Ready    = (state == ARM);
  assign FreqChng = (state == COMMIT);
  assign Busy     = fetch_a || fetch_b;
  assign Running  = is_active(state);

endmodule

// File: tb/tb_osc_sequencer.sv
// Directed bench for osc_sequencer: cycle table for start/retune plus hand sequences for corner cases.
module tb_osc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, freq_req = 1'b0;
  logic [5:0]  freq_sel = '0;
  logic [2:0]  mode_sel = '0;
  logic [15:0] rate_div = '0;
  logic        rom_req, rom_valid;
  logic [6:0]  rom_addr;
  logic [31:0] rom_data;
  logic        enable, ready, freq_chng, busy, running;
  logic [2:0]  mode;
  logic [31:0] init1, init2;

  osc_sequencer #(.IDX_W(6), .DIV_W(16)) dut (
    .Fg_clk(clk), .Resetn(rst_n), .Start(start), .Stop(stop), .FreqReq(freq_req),
    .FreqSel(freq_sel), .ModeSel(mode_sel), .RateDiv(rate_div),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_valid(rom_valid), .rom_data(rom_data),
    .Enable(enable), .Ready(ready), .FreqChng(freq_chng), .Mode(mode),
    .init1(init1), .init2(init2), .Busy(busy), .Running(running)
  );

  always #5 clk = ~clk;

  // Coefficient table model with programmable wait states and a word-1 stall.
  int   waits = 0;
  int   wcnt = 0;
  logic stall_b = 1'b0;

  function automatic logic [31:0] tbl(input logic [6:0] a);
    logic [5:0] i;
    i = a[6:1];
    if (i == 6'd5) return a[0] ? 32'h3FFF_0000 : 32'h0000_4000;
    return a[0] ? (32'h2000_0000 + {26'd0, i}) : (32'h1000_0000 + {18'd0, i, 8'd0});
  endfunction

  assign rom_data  = tbl(rom_addr);
  assign rom_valid = rom_req && !(stall_b && rom_addr[0]) && (wcnt >= waits);

  always @(posedge clk) begin
    if (rom_req && !rom_valid) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  logic [6:0] fetch_log[$];
  always @(posedge clk) if (rom_req && rom_valid) fetch_log.push_back(rom_addr);

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] flags();
    return {ready, enable, freq_chng, busy, running, rom_req};
  endfunction

  typedef struct {
    logic        start;
    logic        freq_req;
    logic [5:0]  sel;
    int          waits;
    logic [5:0]  e_flags;
    logic [6:0]  e_addr;
    logic [31:0] e_i1;
    logic [31:0] e_i2;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic fr, input logic [5:0] sel, input int w,
                              input logic [5:0] f, input logic [6:0] a,
                              input logic [31:0] i1, input logic [31:0] i2);
    vec_t v;
    v.start = st; v.freq_req = fr; v.sel = sel; v.waits = w;
    v.e_flags = f; v.e_addr = a; v.e_i1 = i1; v.e_i2 = i2;
    return v;
  endfunction

  localparam logic [31:0] I5A = 32'h0000_4000, I5B = 32'h3FFF_0000;
  localparam logic [31:0] I9A = 32'h1000_0900, I9B = 32'h2000_0009;
  localparam logic [31:0] I8A = 32'h1000_0800, I8B = 32'h2000_0008;

  vec_t vt[21];

  initial begin
    int   base, fc_cnt, en_cnt, acc;
    logic got, saw7;
    logic [27:0] seq;

    // flags = {Ready, Enable, FreqChng, Busy, Running, rom_req}; record k is observed one cycle later.
    vt[0]  = mk(1, 0, 5, 0, 6'b000101, 7'h0A, 0, 0);
    vt[1]  = mk(0, 0, 0, 0, 6'b000101, 7'h0B, 0, 0);
    vt[2]  = mk(0, 0, 0, 0, 6'b100000, 7'h00, I5A, I5B);
    vt[3]  = mk(0, 0, 0, 0, 6'b000010, 7'h00, I5A, I5B);
    vt[4]  = mk(0, 0, 0, 0, 6'b000010, 7'h00, I5A, I5B);
    vt[5]  = mk(0, 0, 0, 0, 6'b000010, 7'h00, I5A, I5B);
    vt[6]  = mk(0, 0, 0, 0, 6'b010010, 7'h00, I5A, I5B);
    vt[7]  = mk(0, 0, 0, 0, 6'b000010, 7'h00, I5A, I5B);
    vt[8]  = mk(0, 0, 0, 0, 6'b000010, 7'h00, I5A, I5B);
    vt[9]  = mk(0, 0, 0, 0, 6'b000010, 7'h00, I5A, I5B);
    vt[10] = mk(0, 0, 0, 0, 6'b010010, 7'h00, I5A, I5B);
    vt[11] = mk(0, 0, 0, 0, 6'b000010, 7'h00, I5A, I5B);
    vt[12] = mk(0, 1, 9, 2, 6'b000111, 7'h12, I5A, I5B);
    vt[13] = mk(0, 0, 0, 2, 6'b000111, 7'h12, I5A, I5B);
    vt[14] = mk(0, 0, 0, 2, 6'b010111, 7'h12, I5A, I5B);
    vt[15] = mk(0, 0, 0, 2, 6'b000111, 7'h13, I5A, I5B);
    vt[16] = mk(0, 0, 0, 2, 6'b000111, 7'h13, I5A, I5B);
    vt[17] = mk(0, 0, 0, 2, 6'b000111, 7'h13, I5A, I5B);
    vt[18] = mk(0, 0, 0, 2, 6'b011010, 7'h00, I9A, I9B);
    vt[19] = mk(0, 0, 0, 2, 6'b000010, 7'h00, I9A, I9B);
    vt[20] = mk(0, 0, 0, 2, 6'b000010, 7'h00, I9A, I9B);

    // Reset state
    repeat (2) @(negedge clk);
    check("reset outputs", 64'({flags(), rom_addr, mode, enable}), 64'd0);
    check("reset init", {init1, init2}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after reset", 64'(flags()), 64'd0);

    // Start sequence and retune to idx9 with two wait states per word
    for (int k = 0; k < 21; k++) begin
      start = vt[k].start; freq_req = vt[k].freq_req; freq_sel = vt[k].sel;
      waits = vt[k].waits; mode_sel = 3'd2; rate_div = 16'd3;
      @(negedge clk);
      check($sformatf("vec%0d flags", k), 64'(flags()), 64'(vt[k].e_flags));
      if (vt[k].e_flags[0]) check($sformatf("vec%0d addr", k), 64'(rom_addr), 64'(vt[k].e_addr));
      check($sformatf("vec%0d init", k), {init1, init2}, {vt[k].e_i1, vt[k].e_i2});
      check($sformatf("vec%0d mode", k), 64'(mode), 64'd2);
    end
    start = 1'b0; freq_req = 1'b0; mode_sel = 3'd0;

    // Coalescing: idx3 in RUN, then idx7 and idx8 while UP_A is stalled
    base = fetch_log.size();
    fc_cnt = 0;
    freq_req = 1'b1; freq_sel = 6'd3;
    @(negedge clk); fc_cnt += int'(freq_chng);
    freq_sel = 6'd7;
    @(negedge clk); fc_cnt += int'(freq_chng);
    freq_sel = 6'd8;
    @(negedge clk); fc_cnt += int'(freq_chng);
    freq_req = 1'b0; freq_sel = 6'd0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      fc_cnt += int'(freq_chng);
    end
    check("coalesce freqchng count", 64'(fc_cnt), 64'd2);
    check("coalesce fetch count", 64'(fetch_log.size() - base), 64'd4);
    seq = '0; saw7 = 1'b0;
    for (int j = 0; j < 4; j++)
      seq = {seq[20:0], (base + j < fetch_log.size()) ? fetch_log[base + j] : 7'h7F};
    for (int j = base; j < fetch_log.size(); j++)
      if (fetch_log[j][6:1] == 6'd7) saw7 = 1'b1;
    check("coalesce fetch order", 64'(seq), 64'({7'h06, 7'h07, 7'h10, 7'h11}));
    check("coalesce idx7 fetched", 64'(saw7), 64'd0);
    check("coalesce final init", {init1, init2}, {I8A, I8B});
    check("coalesce back in RUN", 64'({busy, running}), 64'b01);

    // Stop while word 1 of a retune is stalled
    waits = 0; stall_b = 1'b1;
    freq_req = 1'b1; freq_sel = 6'd4;
    @(negedge clk);
    freq_req = 1'b0; freq_sel = 6'd0;
    repeat (4) @(negedge clk);
    check("stall busy/req", 64'({busy, rom_req, running}), 64'b111);
    check("stall addr", 64'(rom_addr), 64'h09);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; stall_b = 1'b0;
    check("stop flags", 64'(flags()), 64'd0);
    check("stop init kept", {init1, init2}, {I8A, I8B});
    check("stop mode kept", 64'(mode), 64'd2);
    freq_req = 1'b1; freq_sel = 6'd10;
    @(negedge clk);
    freq_req = 1'b0; freq_sel = 6'd0;
    acc = 0;
    for (int t = 0; t < 5; t++) begin
      acc += int'(|flags());
      @(negedge clk);
    end
    check("idle freqreq ignored", 64'(acc), 64'd0);

    // RateDiv=0, Start in RUN ignored, Start+Stop together
    rate_div = 16'd0; mode_sel = 3'd3; freq_sel = 6'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; freq_sel = 6'd0;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (ready) got = 1'b1;
    end
    check("div0 ready seen", 64'(got), 64'd1);
    en_cnt = 0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      en_cnt += int'(enable);
    end
    check("div0 enable every cycle", 64'(en_cnt), 64'd5);
    check("div0 mode", 64'(mode), 64'd3);
    start = 1'b1; mode_sel = 3'd1; freq_sel = 6'd9;
    @(negedge clk);
    start = 1'b0;
    check("start in RUN ignored", 64'({busy, running, rom_req, ready, mode}), 64'({4'b0100, 3'd3}));
    @(negedge clk);
    check("start in RUN still running", 64'({busy, running}), 64'b01);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start+stop to idle", 64'(flags()), 64'd0);
    @(negedge clk);
    check("start+stop start dropped", 64'(flags()), 64'd0);

    // Asynchronous reset in the middle of LD_B
    waits = 3; mode_sel = 3'd2; freq_sel = 6'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 12 && !got; t++) begin
      @(negedge clk);
      if (busy && rom_addr[0]) got = 1'b1;
    end
    check("reached LD_B", 64'(got), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs", 64'({flags(), rom_addr, mode, enable}), 64'd0);
    check("async reset init", {init1, init2}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    acc = 0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      acc += int'(|flags());
    end
    check("idle after reset release", 64'(acc), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
